// File: rtl/topk_pkg.sv
// Shared types and helpers for the top-K tracker with drain readout.
package topk_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Width needed to hold a count in the range 0..k.
    function automatic int cnt_w(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/topk_drain_if.sv
// Sample input, drain request and readout handshake of the top-K tracker.
interface topk_drain_if #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4
) ();
    import topk_pkg::*;

    logic                  din_valid;
    logic [DATA_WIDTH-1:0] din;
    logic                  drain;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_last;
    logic                  busy;
    logic [cnt_w(K)-1:0]   count;

    modport master (
        output din_valid, din, drain, dout_ready,
        input  dout_valid, dout, dout_last, busy, count
    );

    modport slave (
        input  din_valid, din, drain, dout_ready,
        output dout_valid, dout, dout_last, busy, count
    );

endinterface

// File: rtl/topk_slot.sv
// One cell of the sorted array: value plus valid bit, loadable from din or either neighbour.
module topk_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [DATA_WIDTH-1:0] i_up_data,
    input  logic                  i_up_valid,
    input  logic [DATA_WIDTH-1:0] i_dn_data,
    input  logic                  i_dn_valid,
    input  logic                  i_ins,
    input  logic                  i_take_up,
    input  logic                  i_take_dn,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_gt
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    // NOTE: non-blocking assignments so every slot samples its neighbours' pre-edge values.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_ins) begin
            r_data  <= i_din;
            r_valid <= 1'b1;
        end else if (i_take_up) begin
            r_data  <= i_up_data;
            r_valid <= i_up_valid;
        end else if (i_take_dn) begin
            r_data  <= i_dn_data;
            r_valid <= i_dn_valid;
        end
    end

    // Strict compare: an equal sample lands after the existing equal entry.
    assign o_gt    = !r_valid || (i_din > r_data);
    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/topk_drain.sv
// Keeps the K largest samples in descending order and drains them largest-first on request.
module topk_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4
) (
    input logic         clk,
    input logic         reset,
    topk_drain_if.slave bus
);
    import topk_pkg::*;

    localparam int             CW    = cnt_w(K);
    localparam int             PW    = $clog2(K);
    localparam logic [CW-1:0]  K_CNT = CW'(K);
    localparam logic [CW-1:0]  ONE   = CW'(1);

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_count;

    logic [DATA_WIDTH-1:0] w_data [K];
    logic [K-1:0]          w_valid;
    logic [K-1:0]          w_gt;
    logic [K-1:0]          w_ins;
    logic [K-1:0]          w_take_up;
    logic [PW-1:0]         w_p;
    logic                  w_accept;
    logic                  w_ins_en;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_clear;

    // The compare vector is monotonic in a sorted array, so the first set bit is the slot.
    always_comb begin
        w_p = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (w_gt[i]) w_p = PW'(i);
        end
    end

    assign w_accept = |w_gt;
    assign w_last   = w_pop && (r_count == ONE);
    assign w_clear  = reset || w_last;

    for (genvar gi = 0; gi < K; gi++) begin : g_slot
        logic [DATA_WIDTH-1:0] w_up_data;
        logic                  w_up_valid;
        logic [DATA_WIDTH-1:0] w_dn_data;
        logic                  w_dn_valid;

        if (gi == 0) begin : g_top
            assign w_up_data  = '0;
            assign w_up_valid = 1'b0;
        end else begin : g_mid_up
            assign w_up_data  = w_data[gi-1];
            assign w_up_valid = w_valid[gi-1];
        end

        if (gi == K - 1) begin : g_bottom
            assign w_dn_data  = '0;
            assign w_dn_valid = 1'b0;
        end else begin : g_mid_dn
            assign w_dn_data  = w_data[gi+1];
            assign w_dn_valid = w_valid[gi+1];
        end

        assign w_ins[gi]     = w_ins_en && (w_p == PW'(gi));
        assign w_take_up[gi] = w_ins_en && (w_p <  PW'(gi));

        topk_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
            .clk        (clk),
            .i_clear    (w_clear),
            .i_din      (bus.din),
            .i_up_data  (w_up_data),
            .i_up_valid (w_up_valid),
            .i_dn_data  (w_dn_data),
            .i_dn_valid (w_dn_valid),
            .i_ins      (w_ins[gi]),
            .i_take_up  (w_take_up[gi]),
            .i_take_dn  (w_pop),
            .o_data     (w_data[gi]),
            .o_valid    (w_valid[gi]),
            .o_gt       (w_gt[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= FILL;
        else       r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FILL:  if (bus.drain && r_count != '0) w_next = DRAIN;
            DRAIN: if (w_last)                     w_next = FILL;
        endcase
    end

    always_comb begin
        bus.busy       = 1'b0;
        bus.dout_valid = 1'b0;
        bus.dout       = '0;
        bus.dout_last  = 1'b0;
        w_ins_en       = 1'b0;
        w_pop          = 1'b0;
        unique case (r_state)
            FILL: w_ins_en = bus.din_valid && w_accept;
            DRAIN: begin
                bus.busy       = 1'b1;
                bus.dout_valid = 1'b1;
                bus.dout       = w_data[0];
                bus.dout_last  = (r_count == ONE);
                w_pop          = bus.dout_ready;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || w_last)                   r_count <= '0;
        else if (w_pop)                        r_count <= r_count - ONE;
        else if (w_ins_en && r_count != K_CNT) r_count <= r_count + ONE;
    end

    assign bus.count = r_count;

endmodule
